// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one K-step operand tile and replays it into the
// systolic array with diagonal lane skew, flush zeros and a drain window.
module systolic_feeder #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [SIZE*DATA_W-1:0]   in_a_i,
    input  logic [SIZE*DATA_W-1:0]   in_b_i,
    input  logic                     in_last_i,
    output logic [SIZE*DATA_W-1:0]   a_o,
    output logic [SIZE*DATA_W-1:0]   b_o,
    output logic                     last_o,
    output logic                     ctrl_o,
    output logic                     busy_o,
    output logic                     trunc_o
);

    localparam int VW = SIZE * DATA_W;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(2 * SIZE) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          ctrl_q, ctrl_d;
    logic          last_q, last_d;

    logic [VW-1:0]    mem_a_q [DEPTH];
    logic [VW-1:0]    mem_b_q [DEPTH];
    logic [DEPTH-1:0] mem_l_q;

    logic          accept;
    logic          full_hit;
    logic          pop;
    logic [VW-1:0] src_a;
    logic [VW-1:0] src_b;
    logic          src_last;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready_o = (state_q == S_IDLE) && (count_q < PW'(DEPTH));
    assign accept     = in_valid_i && in_ready_o;
    assign full_hit   = accept && (count_q == PW'(DEPTH - 1));
    assign trunc_o    = full_hit && !in_last_i;
    assign pop        = (state_q == S_STREAM);

    assign src_a    = pop ? mem_a_q[rd_ptr_q[AW-1:0]] : '0;
    assign src_b    = pop ? mem_b_q[rd_ptr_q[AW-1:0]] : '0;
    assign src_last = pop && mem_l_q[rd_ptr_q[AW-1:0]];

    assign busy_o = (state_q != S_IDLE);
    assign ctrl_o = ctrl_q;
    assign last_o = last_q;

    // Tile sequencing: fill in IDLE, replay, flush zeros, then drain window.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cyc_d    = cyc_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_ptr_d = wrap_inc(wr_ptr_q);
                    count_d  = count_q + 1'b1;
                    if (in_last_i || full_hit) begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                rd_ptr_d = wrap_inc(rd_ptr_q);
                count_d  = count_q - 1'b1;
                if (src_last) begin
                    state_d = S_FLUSH;
                    cyc_d   = '0;
                end
            end
            S_FLUSH: begin
                if (cyc_q == CW'(2 * SIZE - 1)) begin
                    state_d = S_DRAIN;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cyc_q == CW'(SIZE - 1)) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ctrl_d = (state_d == S_DRAIN);
        last_d = src_last;
    end

    // Control state; ctrl is a flop so the drain array sees a clean level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cyc_q    <= '0;
            ctrl_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cyc_q    <= cyc_d;
            ctrl_q   <= ctrl_d;
            last_q   <= last_d;
        end
    end

    // Tile storage; a buffer-filling step is stored as the tile's last.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_a_q[wr_ptr_q[AW-1:0]] <= in_a_i;
            mem_b_q[wr_ptr_q[AW-1:0]] <= in_b_i;
            mem_l_q[wr_ptr_q[AW-1:0]] <= in_last_i || full_hit;
        end
    end

    for (genvar j = 0; j < SIZE; j++) begin : g_lane
        logic [DATA_W-1:0] sa_q [j+1];
        logic [DATA_W-1:0] sa_d [j+1];
        logic [DATA_W-1:0] sb_q [j+1];
        logic [DATA_W-1:0] sb_d [j+1];

        // Shift chain: lane j sees the popped element j+1 cycles later.
        always_comb begin
            sa_d[0] = src_a[j*DATA_W +: DATA_W];
            sb_d[0] = src_b[j*DATA_W +: DATA_W];
            for (int s = 1; s <= j; s++) begin
                sa_d[s] = sa_q[s-1];
                sb_d[s] = sb_q[s-1];
            end
        end

        // Skew registers, cleared by reset so an aborted tile vanishes.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int s = 0; s <= j; s++) begin
                    sa_q[s] <= '0;
                    sb_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s <= j; s++) begin
                    sa_q[s] <= sa_d[s];
                    sb_q[s] <= sb_d[s];
                end
            end
        end

        assign a_o[j*DATA_W +: DATA_W] = sa_q[j];
        assign b_o[j*DATA_W +: DATA_W] = sb_q[j];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized tiles against a timeline model of
// skewed replay, flush, drain window, truncation and reset abort.
module tb_systolic_feeder;

    localparam int SIZE   = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int W      = SIZE * DATA_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_last;
    logic [W-1:0] a_o;
    logic [W-1:0] b_o;
    logic         last_o;
    logic         ctrl_o;
    logic         busy_o;
    logic         trunc_o;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] tile_a [$];
    logic [W-1:0] tile_b [$];

    systolic_feeder #(
        .SIZE(SIZE), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
        .a_o(a_o), .b_o(b_o), .last_o(last_o),
        .ctrl_o(ctrl_o), .busy_o(busy_o), .trunc_o(trunc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        for (int j = 0; j < SIZE; j++) v[j*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    // Fill one tile. mode 0 random, 1 = {1,2,3,4}+16k, 2 = a {5,6,7,8}.
    task automatic fill(input int k, input bit toggle, input bit has_last, input int mode);
        int idx = 0;
        int cyc = 0;
        logic vld;
        logic [W-1:0] va, vb;
        logic exp_tr;
        tile_a.delete();
        tile_b.delete();
        while (idx < k) begin
            @(posedge clk); #1;
            vld = toggle ? (cyc % 2 == 0) : 1'b1;
            va = rnd_vec();
            vb = rnd_vec();
            if (mode == 1) begin
                for (int j = 0; j < SIZE; j++) va[j*DATA_W +: DATA_W] = DATA_W'(j + 1 + 16 * idx);
                vb = va;
            end else if (mode == 2) begin
                for (int j = 0; j < SIZE; j++) va[j*DATA_W +: DATA_W] = DATA_W'(5 + j);
            end
            in_valid = vld;
            in_a = va;
            in_b = vb;
            in_last = vld ? (has_last && idx == k - 1) : 1'($urandom);
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill_ready idx=%0d got=%b exp=1", idx, in_ready);
            end
            total++;
            if (busy_o !== 1'b0) begin
                bad++;
                $display("FAIL fill_busy idx=%0d got=%b exp=0", idx, busy_o);
            end
            exp_tr = vld && (idx == DEPTH - 1) && !in_last;
            total++;
            if (trunc_o !== exp_tr) begin
                bad++;
                $display("FAIL fill_trunc idx=%0d got=%b exp=%b", idx, trunc_o, exp_tr);
            end
            if (vld) begin
                tile_a.push_back(va);
                tile_b.push_back(vb);
                idx++;
            end
            cyc++;
        end
    endtask

    // Check cycles t+1..t+nmax after the final accept at cycle t.
    task automatic observe(input bit hold, input int nmax);
        int k;
        int ks;
        logic [W-1:0] ea, eb;
        logic el, ec, eby;
        k = tile_a.size();
        for (int n = 1; n <= nmax; n++) begin
            @(posedge clk); #1;
            in_valid = hold;
            in_a = rnd_vec();
            in_b = rnd_vec();
            in_last = 1'($urandom);
            @(negedge clk);
            ea = '0;
            eb = '0;
            for (int j = 0; j < SIZE; j++) begin
                ks = n - 2 - j;
                if (ks >= 0 && ks < k) begin
                    ea[j*DATA_W +: DATA_W] = tile_a[ks][j*DATA_W +: DATA_W];
                    eb[j*DATA_W +: DATA_W] = tile_b[ks][j*DATA_W +: DATA_W];
                end
            end
            el  = (n == k + 1);
            ec  = (n >= k + 2 * SIZE + 1) && (n <= k + 3 * SIZE);
            eby = (n <= k + 3 * SIZE);
            total++;
            if (a_o !== ea) begin
                bad++;
                $display("FAIL a_o n=%0d got=%h exp=%h", n, a_o, ea);
            end
            total++;
            if (b_o !== eb) begin
                bad++;
                $display("FAIL b_o n=%0d got=%h exp=%h", n, b_o, eb);
            end
            total++;
            if (last_o !== el) begin
                bad++;
                $display("FAIL last_o n=%0d got=%b exp=%b", n, last_o, el);
            end
            total++;
            if (ctrl_o !== ec) begin
                bad++;
                $display("FAIL ctrl_o n=%0d got=%b exp=%b", n, ctrl_o, ec);
            end
            total++;
            if (busy_o !== eby) begin
                bad++;
                $display("FAIL busy_o n=%0d got=%b exp=%b", n, busy_o, eby);
            end
            total++;
            if (in_ready !== !eby) begin
                bad++;
                $display("FAIL in_ready n=%0d got=%b exp=%b", n, in_ready, !eby);
            end
            total++;
            if (trunc_o !== 1'b0) begin
                bad++;
                $display("FAIL trunc_busy n=%0d got=%b exp=0", n, trunc_o);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_o, b_o, last_o, ctrl_o, busy_o, trunc_o} !== '0) begin
            bad++;
            $display("FAIL reset_outs got a=%h b=%h l=%b c=%b bz=%b t=%b exp=0",
                     a_o, b_o, last_o, ctrl_o, busy_o, trunc_o);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got ready=%b busy=%b exp ready=1 busy=0", in_ready, busy_o);
        end
    endtask

    task automatic test_k3();
        fill(3, 1'b0, 1'b1, 1);
        observe(1'b0, 3 + 3 * SIZE + 1);
    endtask

    task automatic test_k1();
        fill(1, 1'b0, 1'b1, 2);
        observe(1'b0, 1 + 3 * SIZE + 1);
    endtask

    task automatic test_trunc();
        fill(DEPTH, 1'b0, 1'b0, 0);
        observe(1'b0, DEPTH + 3 * SIZE + 1);
    endtask

    task automatic test_toggle();
        fill(5, 1'b1, 1'b1, 0);
        observe(1'b0, 5 + 3 * SIZE + 1);
    endtask

    task automatic test_reset_flush();
        fill(3, 1'b0, 1'b1, 0);
        observe(1'b0, 3 + 3);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({a_o, b_o, last_o, ctrl_o, busy_o, trunc_o} !== '0) begin
            bad++;
            $display("FAIL async_reset got a=%h b=%h l=%b c=%b bz=%b exp=0",
                     a_o, b_o, last_o, ctrl_o, busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3 + 3 * SIZE; n++) begin
            @(negedge clk);
            total++;
            if (ctrl_o !== 1'b0 || busy_o !== 1'b0 || a_o !== '0 || b_o !== '0) begin
                bad++;
                $display("FAIL post_abort n=%0d got c=%b bz=%b a=%h b=%h exp=0",
                         n, ctrl_o, busy_o, a_o, b_o);
            end
        end
        test_k3();
    endtask

    task automatic test_hold_valid();
        fill(4, 1'b0, 1'b1, 0);
        observe(1'b1, 4 + 3 * SIZE);
        fill(2, 1'b0, 1'b1, 0);
        observe(1'b0, 2 + 3 * SIZE + 1);
    endtask

    task automatic test_random();
        int k;
        for (int r = 0; r < 5; r++) begin
            k = $urandom_range(1, DEPTH);
            fill(k, 1'($urandom), 1'b1, 0);
            observe(1'($urandom), k + 3 * SIZE);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_k3();
        test_k1();
        test_trunc();
        test_toggle();
        test_reset_flush();
        test_hold_valid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder for the systolic matrix-multiply datapath. Buffers one tile of K operand steps (one `a` column vector and one `b` row vector per step) from an upstream valid/ready stream. It replays the tile into the systolic array wrapper with the diagonal skew the array expects (lane j delayed j cycles), the tile `last` marker, zero flush cycles, and the drain control pulse window. It produces exactly the `a`, `b`, `last`, `ctrl` inputs the array wrapper consumes.

## Interface
- `SIZE`, default `SYS_ARRAY_SIZE` (4): lanes per operand vector, equal to the array dimension.
- `DATA_W`, default 16: bits per lane element (width of `data_t`).
- `DEPTH`, default 16: tile buffer depth; maximum K per tile.
- `clk_i`  in  1: clock, single clock domain.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `in_valid_i`  in  1: upstream step valid.
- `in_ready_o`  out  1: step accepted when `in_valid_i & in_ready_o`.
- `in_a_i`  in  SIZE*DATA_W: `a` vector for one K step, lane 0 in LSBs.
- `in_b_i`  in  SIZE*DATA_W: `b` vector for one K step.
- `in_last_i`  in  1: marks final K step of the tile.
- `a_o`  out  SIZE*DATA_W: skewed `a` lanes to the array.
- `b_o`  out  SIZE*DATA_W: skewed `b` lanes to the array.
- `last_o`  out  1: tile last marker, aligned with lane 0.
- `ctrl_o`  out  1: drain control to the drain array.
- `busy_o`  out  1: high in any state other than IDLE.
- `trunc_o`  out  1: one-cycle pulse when a tile is force-terminated by a full buffer.

## Operation
- Tile buffer: DEPTH-entry FIFO of {a, b, last}. Counters: `wr_ptr`, `rd_ptr`, `count` of $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- `in_ready_o` = (state == IDLE) & (count < DEPTH). Steps are never accepted outside IDLE.
- FSM states:
  - IDLE → STREAM: on the accept of a step with `in_last_i`=1, or on the accept that makes count == DEPTH. In the full case the DEPTH-th entry's stored last bit is forced to 1 and `trunc_o` pulses in that cycle.
  - STREAM: pops one entry per cycle into the skew stage. After the pop of the entry with last=1 → FLUSH. The buffer cannot underflow, because the tile is complete before STREAM is entered.
  - FLUSH: feeds zeros (last=0) for exactly 2*SIZE cycles, so the final step reaches PE[SIZE-1][SIZE-1] and accumulates. Then → DRAIN.
  - DRAIN: holds `ctrl_o`=1 for exactly SIZE cycles and feeds zeros. Then → IDLE.
- Skew stage: lane j of `a` and of `b` passes through j+1 registers. Lane 0 has one register; lane SIZE-1 has SIZE registers. Register input is the popped entry in STREAM and zero otherwise.
- `last_o`: the popped last bit registered once, so it is aligned with lane 0.
- No arithmetic is performed on data. Values pass bit-exact.

## Timing
- Reset (async, `rst_i`=1): state IDLE, FIFO emptied (pointers and count 0), all skew registers 0. `a_o`/`b_o`=0, `last_o`=0, `ctrl_o`=0, `busy_o`=0, `trunc_o`=0, `in_ready_o`=1 after reset deasserts.
- Reset mid-tile aborts the tile. No partial drain follows.
- Accept-to-start: the last accept at cycle t puts the state in STREAM at t+1. The first pop is at t+1, lane 0 appears at t+2, and lane j at t+2+j.
- A K-step tile takes K STREAM + 2*SIZE FLUSH + SIZE DRAIN cycles. `busy_o` is high for exactly that span.
- `ctrl_o` rises on the first DRAIN cycle and is registered, glitch-free.
- `in_valid_i` while `in_ready_o`=0 is ignored. Upstream must hold data until accepted.
- K=1 tile: a single accepted step with last=1 goes directly to STREAM.

## Test plan
- SIZE=4, K=3 steps a=b={1,2,3,4}+16k, last on k=2 → lane j shows step k at cycle t+2+k+j. `last_o`=1 only at t+4. Zeros for 8 FLUSH cycles, then `ctrl_o`=1 for 4 cycles. `busy_o` is high for 15 cycles.
- K=1 tile with a={5,6,7,8} → lane j shows 5+j at t+2+j. `last_o` is high at t+2.
- DEPTH=16 steps without last → `trunc_o` pulses on the 16th accept. The 16th step is emitted with `last_o`=1. `in_ready_o` is 0 from that cycle until IDLE.
- Upstream valid toggling 1,0,1,0 during fill → only handshaken steps are buffered, in order. No STREAM starts before the last step.
- `rst_i` asserted during FLUSH → all outputs are 0 asynchronously and `ctrl_o` never rises. The next tile after reset behaves as in the first scenario.
- `in_valid_i` held high during STREAM/FLUSH/DRAIN → `in_ready_o`=0 and no buffer change. The next tile is accepted on the first IDLE cycle.
